// File: rtl/muldiv_pkg.sv
// Shared types and op predicates for the multi-cycle multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MUL  = 2'd0,
      OP_MULU = 2'd1,
      OP_DIV  = 2'd2,
      OP_DIVU = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic logic is_signed(input op_e op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic is_div(input op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negator: y = neg ? -x : x.
module muldiv_signfix #(
   parameter int W = 32
) (
   input  logic [W-1:0] x,
   input  logic         neg,
   output logic [W-1:0] y
);

   assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned MUL/DIV (shift-add, restoring divide) with valid/ready handshakes.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC as soon as the remaining multiplier is zero.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int W2    = 2 * WIDTH;

   op_e              op_in, op_q;
   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [W2-1:0]    acc, mcand;
   logic [WIDTH-1:0] mplier, quo, dvsr;
   logic [WIDTH:0]   rem;
   logic             neg_q, neg_r;

   logic             sa_in, sb_in;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign op_in = op_e'(op);
   assign sa_in = is_signed(op_in) & a[WIDTH-1];
   assign sb_in = is_signed(op_in) & b[WIDTH-1];

   // Magnitudes are unsigned, so |MIN| is simply 2^(WIDTH-1).
   muldiv_signfix #(.W(WIDTH)) u_fix_a (.x(a), .neg(sa_in), .y(a_mag));
   muldiv_signfix #(.W(WIDTH)) u_fix_b (.x(b), .neg(sb_in), .y(b_mag));

   // Restoring divide step: shift in next dividend bit, trial-subtract divisor.
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;
   logic             q_bit;

   assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
   assign diff   = {1'b0, rem_sh} - {2'b00, dvsr};
   assign q_bit  = ~diff[WIDTH+1];

   logic [W2-1:0] acc_nx;
   assign acc_nx = mplier[0] ? (acc + mcand) : acc;

   logic early_done;
`ifdef MULDIV_EARLY_OUT_EN
   assign early_done = !is_div(op_q) && ((mplier >> 1) == '0);
`else
   assign early_done = 1'b0;
`endif

   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   muldiv_signfix #(.W(W2))    u_fix_p (.x(acc),             .neg(neg_q), .y(prod_fix));
   muldiv_signfix #(.W(WIDTH)) u_fix_q (.x(quo),             .neg(neg_q), .y(quo_fix));
   muldiv_signfix #(.W(WIDTH)) u_fix_r (.x(rem[WIDTH-1:0]),  .neg(neg_r), .y(rem_fix));

   // The stored remainder is always below the divisor, so its top bit stays clear.
   logic unused;
   assign unused = rem[WIDTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         start_ready  <= 1'b1;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         hi           <= '0;
         lo           <= '0;
         div_by_zero  <= 1'b0;
         op_q         <= OP_MUL;
         cnt          <= '0;
         acc          <= '0;
         mcand        <= '0;
         mplier       <= '0;
         quo          <= '0;
         rem          <= '0;
         dvsr         <= '0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid && start_ready) begin
                  op_q        <= op_in;
                  neg_q       <= sa_in ^ sb_in;
                  neg_r       <= sa_in;
                  cnt         <= CNT_W'(WIDTH);
                  acc         <= '0;
                  mcand       <= {{WIDTH{1'b0}}, a_mag};
                  mplier      <= b_mag;
                  quo         <= a_mag;
                  rem         <= '0;
                  dvsr        <= b_mag;
                  div_by_zero <= 1'b0;
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
                  if (is_div(op_in) && (b == '0)) begin
                     state        <= DONE;
                     hi           <= a;
                     lo           <= '1;
                     div_by_zero  <= 1'b1;
                     result_valid <= 1'b1;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               cnt <= cnt - CNT_W'(1);
               if (is_div(op_q)) begin
                  quo <= {quo[WIDTH-2:0], q_bit};
                  rem <= q_bit ? diff[WIDTH:0] : rem_sh;
               end else begin
                  acc    <= acc_nx;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
               end
               if ((cnt == CNT_W'(1)) || early_done)
                  state <= FIXUP;
            end
            FIXUP: begin
               if (is_div(op_q)) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
               result_valid <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  start_ready  <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random bench for muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start_valid = 1'b0;
   logic         result_ready = 1'b0;
   logic [1:0]   op = 2'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         start_ready, result_valid, div_by_zero, busy;
   logic [W-1:0] hi, lo;

   int n_assert = 0;
   int n_fail   = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .op           (op),
      .a            (a),
      .b            (b),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .hi           (hi),
      .lo           (lo),
      .div_by_zero  (div_by_zero),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: full 2W product, or truncating quotient/remainder.
   task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
      longint      sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ed = 1'b0;
      eh = '0;
      el = '0;
      case (o)
         2'd0: begin p = sx * sy; {eh, el} = p; end
         2'd1: begin p = {32'b0, x} * {32'b0, y}; {eh, el} = p; end
         default: begin
            if (y == '0) begin
               eh = x; el = '1; ed = 1'b1;
            end else if (o == 2'd2) begin
               q = sx / sy; r = sx % sy;
               eh = r[W-1:0]; el = q[W-1:0];
            end else begin
               eh = x % y; el = x / y;
            end
         end
      endcase
   endtask

   function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] y);
      if (o[1] && (y == '0)) return 1;
`ifdef MULDIV_EARLY_OUT_EN
      if (!o[1]) begin
         logic [W-1:0] m;
         int bl;
         m  = (o == 2'd0 && y[W-1]) ? (~y + 1'b1) : y;
         bl = 1;
         for (int i = 0; i < W; i++) if (m[i]) bl = i + 1;
         return bl + 2;
      end
`endif
      return W + 2;
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int bp);
      logic [W-1:0] eh, el;
      logic         ed;
      int           n;
      bit           hold_ok;
      model(o, x, y, eh, el, ed);
      @(negedge clk);
      check("start_ready_idle", 64'(start_ready), 64'd1);
      op = o; a = x; b = y; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
      n = 1;
      while (!result_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 64'(n), 64'(exp_lat(o, y)));
      check("hi", 64'(hi), 64'(eh));
      check("lo", 64'(lo), 64'(el));
      check("div_by_zero", 64'(div_by_zero), 64'(ed));
      check("busy_done", 64'(busy), 64'd1);
      check("start_ready_done", 64'(start_ready), 64'd0);
      if (bp > 0) begin
         hold_ok = 1'b1;
         repeat (bp) begin
            start_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            if (!(result_valid && !start_ready && hi == eh && lo == el)) hold_ok = 1'b0;
         end
         start_valid = 1'b0;
         check("backpressure_hold", 64'(hold_ok), 64'd1);
      end
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      check("release_valid", 64'(result_valid), 64'd0);
      check("release_ready", 64'(start_ready), 64'd1);
   endtask

   initial begin
      logic [1:0]   ro;
      logic [W-1:0] rx, ry;
      #1 rst = 1'b0;
      #2;
      check("rst_result_valid", 64'(result_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_start_ready", 64'(start_ready), 64'd1);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(2'd3, 32'd100, 32'd0, 0);
      run_op(2'd3, 32'd100, 32'd7, 0);
      run_op(2'd1, $urandom, $urandom, 10);

      // Asynchronous reset in the middle of a long multiply.
      @(negedge clk);
      op = 2'd1; a = $urandom | 32'h1; b = $urandom | 32'h8000_0000; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      check("busy_before_reset", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      check("midcalc_rst_valid", 64'(result_valid), 64'd0);
      check("midcalc_rst_busy", 64'(busy), 64'd0);
      check("midcalc_rst_ready", 64'(start_ready), 64'd1);
      check("midcalc_rst_hi", 64'(hi), 64'd0);
      check("midcalc_rst_lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      run_op(2'd1, 32'd6, 32'd7, 0);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = $urandom;
         ry = $urandom;
         case ($urandom_range(0, 7))
            0: ry = '0;
            1: ry = 32'd1;
            2: ry = '1;
            3: rx = 32'h8000_0000;
            4: ry = ry >> $urandom_range(0, 31);
            default: ;
         endcase
         run_op(ro, rx, ry, (i % 9 == 0) ? 3 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle integer multiply/divide unit. It is the next-generation companion to the single-cycle ALU.
- It runs signed and unsigned MUL/DIV over WIDTH bits and returns a 2*WIDTH result split into hi and lo, which the core latches into HI/LO.
- Valid/ready on both the start side and the result side, so the core can stall on busy.

Parameters:
- WIDTH, 32, operand width in bits; legal range 8..64, even numbers only.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; one clock, reset asynchronous and active-low.
- start_valid  in  1  request present.
- start_ready  out  1  unit can accept a request; high only in IDLE.
- op  in  2  operation: 0 MUL, 1 MULU, 2 DIV, 3 DIVU.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- result_valid  out  1  hi, lo and div_by_zero are valid.
- result_ready  in  1  consumer accepts the result.
- hi  out  WIDTH  MUL: product[2W-1:W]. DIV: remainder.
- lo  out  WIDTH  MUL: product[W-1:0]. DIV: quotient.
- div_by_zero  out  1  last DIV/DIVU had b==0.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE.
  - hi, lo, div_by_zero, result_valid and busy are 0; start_ready is 1.
  - Any in-flight operation is aborted with no residue.
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - Accept when start_valid && start_ready. The unit latches op, a, b.
  - For signed ops it records sign flags and operates on magnitudes; |MIN| is treated as unsigned 2^(W-1).
  - Next state is CALC. Exception: DIV/DIVU with b==0 goes straight to DONE.
- CALC, multiply:
  - Shift-add. 2W accumulator, 2W multiplicand shifted left each cycle, multiplier shifted right each cycle.
  - Adds the multiplicand when multiplier[0]=1.
- CALC, divide:
  - Restoring division, one quotient bit per cycle, MSB first.
  - Partial remainder is W+1 bits; subtract, keep the result if non-negative, otherwise restore.
- CALC duration: counter loads WIDTH; CALC lasts exactly WIDTH cycles, then FIXUP.
- FIXUP (1 cycle) applies sign correction:
  - MUL: negate the 2W product if sign(a)^sign(b).
  - DIV: negate the quotient if sign(a)^sign(b); the remainder takes the sign of the dividend (truncating division).
  - Writes hi/lo, then DONE.
- DONE:
  - result_valid=1; hi/lo/div_by_zero are held stable.
  - Leave to IDLE when result_ready=1.
  - start_ready stays 0 in DONE, so there is no same-cycle re-accept. Back-to-back operations have a one-cycle bubble.
- Latency: result_valid rises WIDTH+2 cycles after the accept edge; divide-by-zero takes 1 cycle.
- Divide by zero: lo = all ones, hi = a, div_by_zero=1. div_by_zero is cleared on the next accepted op.
- Signed overflow, DIV MIN / -1: lo=MIN, hi=0, no flag. This falls out of the magnitude arithmetic.
- MUL/MULU never overflow: the full 2W product is always returned.
- Inputs a, b, op are don't-care outside the accept cycle.
- result_ready is ignored outside DONE.
- If rst is asserted with result_valid=1, the result is lost; the consumer must reissue.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - MUL/MULU leaves CALC at the end of the first cycle in which the shifted multiplier becomes 0.
  - CALC length is max(1, index of highest set bit of |b| + 1). Example: b=1 gives result_valid 3 cycles after accept.
  - DIV timing is unchanged.
- Undefined: every op uses fixed WIDTH-cycle CALC timing.
- Results are bit-identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - op enum: OP_MUL=0, OP_MULU=1, OP_DIV=2, OP_DIVU=3.
  - state enum: IDLE, CALC, FIXUP, DONE.
  - predicate functions is_signed(op) and is_div(op).
- One sub-module is natural: muldiv_signfix, a combinational conditional two's-complement negator parametrised by width.
  - Instantiated at W for the operand magnitudes and the quotient/remainder, and at 2W for the product.
- Control and the datapath registers stay in muldiv_unit.

Test Plan:
- MULU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; result_valid exactly 34 cycles after accept (feature off).
- MUL a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU a=100 b=0 -> result_valid 1 cycle after accept; div_by_zero=1, lo=0xFFFFFFFF, hi=100. Next DIVU 100/7 -> lo=14 hi=2, div_by_zero=0.
- Backpressure: hold result_ready=0 for 10 cycles in DONE -> hi/lo stable, start_ready=0, start_valid ignored. Raise result_ready -> IDLE next cycle, start_ready=1.
- Reset mid-CALC (cycle 10 of MULU) -> result_valid=0 and busy=0 immediately, with no clock edge. After release, MULU 6*7 -> lo=42 hi=0. With MULDIV_EARLY_OUT_EN, MULU 6*7 -> result_valid 5 cycles after accept.
